// File: rtl/cell_pkg.sv
// Shared types for the Cell bfpu result path: vector width and drain FSM states.
package cell_pkg;
   localparam int BIT_VEC_SIZE     = 128;
   localparam int BIT_VEC_SIZE_LOG = 7;

   typedef logic [BIT_VEC_SIZE-1:0] bitvec_t;

   typedef enum logic {DRN_IDLE, DRN_EMIT} drain_state_e;
endpackage

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO with simultaneous push/pop and a registered count.
module vec_fifo
   import cell_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  bitvec_t       wdata,
   output bitvec_t       rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   bitvec_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign pop_ok  = pop && !empty;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/cell_result_drain.sv
// Drains bfpu result vectors: queues them and streams set-bit row indices, lowest first.
//  state    | meaning
//  DRN_IDLE | no vector in the work register; waiting for the FIFO
//  DRN_EMIT | work register holds a vector; presenting its lowest set bit
module cell_result_drain
   import cell_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_CNT_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BIT_VEC_SIZE-1:0]     vec_in,
   input  logic                        vec_valid_in,
   output logic                        fifo_full,
   output logic [BIT_VEC_SIZE_LOG-1:0] idx_out,
   output logic                        idx_valid,
   input  logic                        idx_ready,
   output logic                        idx_last,
   output logic                        idx_empty,
   output logic                        overflow,
   output logic [DROP_CNT_W-1:0]       drop_cnt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   drain_state_e                state_q, state_d;
   bitvec_t                     w_q, w_d;
   bitvec_t                     w_rest;
   bitvec_t                     fifo_rdata;
   logic [CW-1:0]               fifo_count;
   logic                        fifo_empty;
   logic                        fifo_pop;
   logic                        drop;
   logic                        w_zero;
   logic                        w_single;
   logic                        xfer;
   logic [BIT_VEC_SIZE_LOG-1:0] lsb_idx;
   logic                        overflow_q;
   logic [DROP_CNT_W-1:0]       drop_cnt_q;

   vec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vec_valid_in),
      .pop   (fifo_pop),
      .wdata (vec_in),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Scan from the top so the last hit, i.e. the lowest set bit, wins.
   always_comb begin
      lsb_idx = '0;
      for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
         if (w_q[i]) lsb_idx = BIT_VEC_SIZE_LOG'(i);
      end
   end

   assign w_rest   = w_q & (w_q - bitvec_t'(1));
   assign w_zero   = (w_q == '0);
   assign w_single = (w_rest == '0);

   assign idx_valid = (state_q == DRN_EMIT);
   assign idx_out   = idx_valid ? lsb_idx : '0;
   assign idx_empty = idx_valid && w_zero;
   assign idx_last  = idx_valid && w_single;
   assign xfer      = idx_valid && idx_ready;
   assign drop      = vec_valid_in && fifo_full && !fifo_pop;

   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      fifo_pop = 1'b0;
      case (state_q)
         DRN_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               w_d      = fifo_rdata;
               state_d  = DRN_EMIT;
            end
         end
         DRN_EMIT: begin
            if (xfer) begin
               if (!w_single) begin
                  w_d = w_rest;
               end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  w_d      = fifo_rdata;
               end else begin
                  w_d     = '0;
                  state_d = DRN_IDLE;
               end
            end
         end
         default: state_d = DRN_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= DRN_IDLE;
         w_q        <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
         end
      end
   end

   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule
